// File: rtl/bias_bank_add_pkg.sv
// Shared constants and helpers for the bias stage that sits between the adder tree
// and the activation/requant stage.
package bias_bank_add_pkg;

    localparam int BB_DW       = 18;
    localparam int BB_ACC_W    = 24;
    localparam int BB_N_LANES  = 16;
    localparam int BB_N_GROUPS = 4;

    localparam logic signed [BB_DW-1:0] BB_SAT_MAX = {1'b0, {(BB_DW-1){1'b1}}};
    localparam logic signed [BB_DW-1:0] BB_SAT_MIN = {1'b1, {(BB_DW-1){1'b0}}};

    // Low bit index of a lane inside a flattened multi-lane bus.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/bias_sat_lane.sv
// One lane of the bias stage: sign-extended accumulator + bias, saturated to DW bits.
module bias_sat_lane
    import bias_bank_add_pkg::*;
#(
    parameter int DW    = BB_DW,
    parameter int ACC_W = BB_ACC_W
) (
    input  logic signed [ACC_W-1:0] acc_i,
    input  logic signed [DW-1:0]    bias_i,
    output logic signed [DW-1:0]    sum_o,
    output logic                    sat_o
);

    localparam int SW = ACC_W + 1;
    localparam logic signed [SW-1:0] MAX_S = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_S = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic signed [SW-1:0] sum_full;

    // One guard bit above the accumulator is enough: bias never exceeds the accumulator range.
    assign sum_full = {acc_i[ACC_W-1], acc_i} + {{(SW-DW){bias_i[DW-1]}}, bias_i};

    // NOTE: every output gets a default first so no path through the block can infer a latch.
    always_comb begin
        sum_o = sum_full[DW-1:0];
        sat_o = 1'b0;
        if (sum_full > MAX_S) begin
            sum_o = MAX_S[DW-1:0];
            sat_o = 1'b1;
        end else if (sum_full < MIN_S) begin
            sum_o = MIN_S[DW-1:0];
            sat_o = 1'b1;
        end
    end

endmodule

// File: rtl/bias_bank_add.sv
// Runtime-loadable per-channel bias bank: adds the current group's biases to each
// accumulator beat in a 2-stage pipeline and steps through channel groups.
module bias_bank_add
    import bias_bank_add_pkg::*;
#(
    parameter int N_adder_tree = BB_N_LANES,
    parameter int DW           = BB_DW,
    parameter int ACC_W        = BB_ACC_W,
    parameter int N_GROUPS     = BB_N_GROUPS,
    parameter int AW           = $clog2(N_GROUPS * N_adder_tree),
    parameter int GW           = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [AW-1:0]                 wr_addr,
    input  logic [DW-1:0]                 wr_data,
    input  logic                          grp_restart,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_adder_tree*ACC_W-1:0] in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N_adder_tree*DW-1:0]    out_data,
    output logic [GW-1:0]                 out_grp,
    output logic [N_adder_tree-1:0]       out_sat
);

    logic                          en;
    logic                          accept;
    logic [GW-1:0]                 ptr_q, ptr_d;
    logic [GW-1:0]                 grp_sel;
    logic [DW-1:0]                 bias_rd [N_GROUPS][N_adder_tree];

    logic                          s1_valid_q;
    logic [N_adder_tree*ACC_W-1:0] s1_acc_q;
    logic [N_adder_tree*DW-1:0]    s1_bias_q, s1_bias_d;
    logic [GW-1:0]                 s1_grp_q;

    logic                          s2_valid_q;
    logic [N_adder_tree*DW-1:0]    s2_data_q, sum_d;
    logic [N_adder_tree-1:0]       s2_sat_q, sat_d;
    logic [GW-1:0]                 s2_grp_q;

    // Single global enable: any stalled output freezes the whole pipe, bubbles included.
    assign en       = out_ready | ~s2_valid_q;
    assign accept   = in_valid & en;
    assign in_ready = en;

    assign grp_sel = grp_restart ? '0 : ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (grp_sel == GW'(N_GROUPS - 1)) ? '0 : grp_sel + 1'b1;
        end else if (grp_restart) begin
            ptr_d = '0;
        end
    end

    for (genvar g = 0; g < N_GROUPS; g++) begin : gen_grp
        for (genvar l = 0; l < N_adder_tree; l++) begin : gen_bias
            logic [DW-1:0] b_q;

            // NOTE: the bias bank must read as zero after reset, so each entry is reset
            // explicitly rather than left as an uninitialised memory.
            // Out-of-range addresses match no entry and are dropped.
            always_ff @(posedge clk) begin
                if (rst) begin
                    b_q <= '0;
                end else if (wr_en && (wr_addr == AW'(g * N_adder_tree + l))) begin
                    b_q <= wr_data;
                end
            end

            assign bias_rd[g][l] = b_q;
        end
    end

    for (genvar l = 0; l < N_adder_tree; l++) begin : gen_lane
        assign s1_bias_d[l*DW +: DW] = bias_rd[grp_sel][l];

        bias_sat_lane #(
            .DW    (DW),
            .ACC_W (ACC_W)
        ) u_lane (
            .acc_i  (s1_acc_q[lane_lo(l, ACC_W) +: ACC_W]),
            .bias_i (s1_bias_q[lane_lo(l, DW) +: DW]),
            .sum_o  (sum_d[lane_lo(l, DW) +: DW]),
            .sat_o  (sat_d[l])
        );
    end

    // NOTE: S1 payload needs no reset; it is only consumed when s1_valid_q is set.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_acc_q  <= in_data;
            s1_bias_q <= s1_bias_d;
            s1_grp_q  <= grp_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_sat_q   <= '0;
            s2_grp_q   <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (en) begin
                s1_valid_q <= accept;
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= sum_d;
                    s2_sat_q  <= sat_d;
                    s2_grp_q  <= s1_grp_q;
                end
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_sat   = s2_sat_q;
    assign out_grp   = s2_grp_q;

endmodule

// File: tb/tb_bias_bank_add.sv
// Scoreboard bench for bias_bank_add: a behavioural model predicts every beat at
// acceptance and results are compared when the DUT hands them over.
module tb_bias_bank_add;
    import bias_bank_add_pkg::*;

    localparam int N     = 16;
    localparam int DW    = 18;
    localparam int ACC_W = 24;
    localparam int NG    = 4;
    localparam int AW    = 6;
    localparam int GW    = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [AW-1:0]     wr_addr = '0;
    logic [DW-1:0]     wr_data = '0;
    logic              grp_restart = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [N*ACC_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [N*DW-1:0]   out_data;
    logic [GW-1:0]     out_grp;
    logic [N-1:0]      out_sat;

    always #5 clk = ~clk;

    bias_bank_add dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .grp_restart (grp_restart),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_grp     (out_grp),
        .out_sat     (out_sat)
    );

    typedef struct {
        logic [N*DW-1:0] data;
        logic [GW-1:0]   grp;
        logic [N-1:0]    sat;
    } exp_t;

    exp_t            sb[$];
    exp_t            mon_e;
    int              bias_m[N*NG];
    int              ptr_m = 0;
    int              total = 0;
    int              bad = 0;
    logic [GW-1:0]   grp_log[$];
    logic [N*DW-1:0] data_log[$];
    logic [N-1:0]    sat_log[$];

    function automatic exp_t model_beat(input logic [N*ACC_W-1:0] acc, input int g);
        exp_t e;
        int   a, s;
        for (int i = 0; i < N; i++) begin
            a = $signed(acc[i*ACC_W +: ACC_W]);
            s = a + bias_m[g*N + i];
            e.sat[i] = 1'b0;
            if (s > int'(BB_SAT_MAX)) begin
                s = int'(BB_SAT_MAX);
                e.sat[i] = 1'b1;
            end else if (s < int'(BB_SAT_MIN)) begin
                s = int'(BB_SAT_MIN);
                e.sat[i] = 1'b1;
            end
            e.data[i*DW +: DW] = DW'(s);
        end
        e.grp = GW'(g);
        return e;
    endfunction

    function automatic int lane_of(input logic [N*DW-1:0] d, input int i);
        logic signed [DW-1:0] t;
        t = d[i*DW +: DW];
        return int'(t);
    endfunction

    // Model update and result comparison, half a cycle away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            foreach (bias_m[k]) bias_m[k] = 0;
            ptr_m = 0;
        end else begin
            if (out_valid && out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: DUT gave beat grp=%0d, none expected", out_grp);
                end else begin
                    mon_e = sb.pop_front();
                    if (out_data !== mon_e.data || out_grp !== mon_e.grp || out_sat !== mon_e.sat) begin
                        bad++;
                        $display("FAIL sb_beat: got grp=%0d sat=%h data=%h want grp=%0d sat=%h data=%h",
                                 out_grp, out_sat, out_data, mon_e.grp, mon_e.sat, mon_e.data);
                    end
                    grp_log.push_back(out_grp);
                    data_log.push_back(out_data);
                    sat_log.push_back(out_sat);
                end
            end
            if (in_valid && in_ready) begin
                int g;
                g = grp_restart ? 0 : ptr_m;
                sb.push_back(model_beat(in_data, g));
                ptr_m = (g == NG - 1) ? 0 : g + 1;
            end else if (grp_restart) begin
                ptr_m = 0;
            end
            if (wr_en && wr_addr < N*NG) bias_m[wr_addr] = $signed(wr_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all_acc(input int v);
        for (int i = 0; i < N; i++) in_data[i*ACC_W +: ACC_W] = ACC_W'(v);
    endtask

    task automatic send(input bit restart);
        in_valid    = 1'b1;
        grp_restart = restart;
        tick();
        in_valid    = 1'b0;
        grp_restart = 1'b0;
    endtask

    task automatic write_bias(input int a, input int v);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = DW'(v);
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        tick();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: %0d beats still pending, want 0", sb.size());
        end
    endtask

    task automatic clear_logs();
        grp_log.delete();
        data_log.delete();
        sat_log.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if (out_valid !== 1'b0 || out_grp !== '0 || out_data !== '0 || out_sat !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%b grp=%0d sat=%h data=%h want all 0",
                     out_valid, out_grp, out_sat, out_data);
        end
        rst = 1'b0;
        tick();
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_group_walk();
        for (int a = 0; a < N*NG; a++) write_bias(a, a);
        set_all_acc(0);
        clear_logs();
        in_valid = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL latency_1: out_valid got %b want 0", out_valid);
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || out_grp !== 2'd0) begin
            bad++;
            $display("FAIL latency_2: got valid=%b grp=%0d want valid=1 grp=0", out_valid, out_grp);
        end
        tick();
        tick();
        in_valid = 1'b0;
        drain();
        total++;
        if (grp_log.size() != 4) begin
            bad++;
            $display("FAIL walk_count: got %0d beats want 4", grp_log.size());
        end else begin
            for (int g = 0; g < 4; g++) begin
                total++;
                if (grp_log[g] !== GW'(g) || lane_of(data_log[g], 5) != 16*g + 5
                    || lane_of(data_log[g], 15) != 16*g + 15) begin
                    bad++;
                    $display("FAIL walk_beat%0d: got grp=%0d l5=%0d l15=%0d want grp=%0d l5=%0d l15=%0d",
                             g, grp_log[g], lane_of(data_log[g], 5), lane_of(data_log[g], 15),
                             g, 16*g + 5, 16*g + 15);
                end
            end
        end
    endtask

    task automatic test_saturation();
        int acc_v[7]  = '{131000, -131000, -5, 131068, 131068, -131077, -131079};
        int want_v[7] = '{131071, -131072, -2, 131071, 131071, -131072, -131072};
        bit want_s[7] = '{1, 1, 0, 0, 1, 0, 1};
        write_bias(0, 1000);
        write_bias(1, -1000);
        write_bias(2, 3);
        set_all_acc(0);
        for (int i = 0; i < 7; i++) in_data[i*ACC_W +: ACC_W] = ACC_W'(acc_v[i]);
        clear_logs();
        send(1'b1);
        drain();
        total++;
        if (data_log.size() != 1) begin
            bad++;
            $display("FAIL sat_count: got %0d beats want 1", data_log.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                total++;
                if (lane_of(data_log[0], i) != want_v[i] || sat_log[0][i] !== want_s[i]) begin
                    bad++;
                    $display("FAIL sat_lane%0d: got %0d sat=%b want %0d sat=%b",
                             i, lane_of(data_log[0], i), sat_log[0][i], want_v[i], want_s[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        set_all_acc(100);
        clear_logs();
        in_valid    = 1'b1;
        grp_restart = 1'b1;
        tick();
        grp_restart = 1'b0;
        tick();
        set_all_acc(777);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL hold_empty%0d: no beat pending, want 2", c);
            end else if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_grp !== 2'd0
                         || out_data !== sb[0].data) begin
                bad++;
                $display("FAIL hold%0d: got valid=%b in_ready=%b grp=%0d data=%h want 1 0 0 %h",
                         c, out_valid, in_ready, out_grp, out_data, sb[0].data);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        total++;
        if (grp_log.size() != 2 || grp_log[0] !== 2'd0 || grp_log[1] !== 2'd1) begin
            bad++;
            $display("FAIL release_order: got %0d beats first grp=%0d want 2 beats grp 0 then 1",
                     grp_log.size(), grp_log.size() > 0 ? grp_log[0] : 2'd0);
        end
    endtask

    task automatic test_restart();
        logic [GW-1:0] want[8] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
        set_all_acc(0);
        clear_logs();
        send(1'b1);
        send(1'b0);
        send(1'b1);
        send(1'b0);
        send(1'b0);
        send(1'b0);
        send(1'b0);
        grp_restart = 1'b1;
        tick();
        grp_restart = 1'b0;
        send(1'b0);
        drain();
        total++;
        if (grp_log.size() != 8) begin
            bad++;
            $display("FAIL restart_count: got %0d beats want 8", grp_log.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                total++;
                if (grp_log[k] !== want[k]) begin
                    bad++;
                    $display("FAIL restart_grp%0d: got %0d want %0d", k, grp_log[k], want[k]);
                end
            end
        end
    endtask

    task automatic test_write_collide();
        set_all_acc(0);
        clear_logs();
        send(1'b1);
        wr_en   = 1'b1;
        wr_addr = AW'(17);
        wr_data = DW'(-7);
        send(1'b0);
        wr_en = 1'b0;
        send(1'b0);
        send(1'b0);
        send(1'b0);
        send(1'b0);
        drain();
        total++;
        if (data_log.size() != 6) begin
            bad++;
            $display("FAIL collide_count: got %0d beats want 6", data_log.size());
        end else begin
            total++;
            if (grp_log[1] !== 2'd1 || lane_of(data_log[1], 1) != 17) begin
                bad++;
                $display("FAIL collide_old: got grp=%0d lane1=%0d want grp=1 lane1=17",
                         grp_log[1], lane_of(data_log[1], 1));
            end
            total++;
            if (grp_log[5] !== 2'd1 || lane_of(data_log[5], 1) != -7) begin
                bad++;
                $display("FAIL collide_new: got grp=%0d lane1=%0d want grp=1 lane1=-7",
                         grp_log[5], lane_of(data_log[5], 1));
            end
        end
    endtask

    task automatic test_reset_midstream();
        set_all_acc(0);
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b0 || out_grp !== 2'd0) begin
            bad++;
            $display("FAIL midreset: got valid=%b grp=%0d want valid=0 grp=0", out_valid, out_grp);
        end
        rst = 1'b0;
        set_all_acc(5);
        clear_logs();
        send(1'b0);
        drain();
        total++;
        if (data_log.size() != 1 || grp_log[0] !== 2'd0 || lane_of(data_log[0], 0) != 5
            || lane_of(data_log[0], 15) != 5) begin
            bad++;
            $display("FAIL midreset_bias: got %0d beats lane0=%0d want 1 beat grp 0 lanes=5",
                     data_log.size(), data_log.size() > 0 ? lane_of(data_log[0], 0) : 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_group_walk();
        test_saturation();
        test_back_to_back();
        test_restart();
        test_write_collide();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
